// File: rtl/nmr_pkg.sv
// rtl/nmr_pkg.sv - shared state encoding, status field layout and defaults for the NMR sequencer
package nmr_pkg;

  // Sequencer states; the numeric values appear in the sts register
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ARM    = 4'd1,
    ST_EXCITE = 4'd2,
    ST_DEAD   = 4'd3,
    ST_ACQ    = 4'd4,
    ST_RELAX  = 4'd5,
    ST_DONE   = 4'd6
  } nmr_state_e;

  // sts = {state[3:0], 4'b0, echo_idx[7:0], rep_idx[15:0]}
  localparam int STS_STATE_LSB = 28;
  localparam int STS_STATE_W   = 4;
  localparam int STS_ECHO_LSB  = 16;
  localparam int STS_ECHO_W    = 8;
  localparam int STS_REP_LSB   = 0;
  localparam int STS_REP_W     = 16;

  // Default length of the downstream reset pulse issued in ARM
  localparam int RST_CYC_DEF = 4;

  // A sequence is in progress from ARM through RELAX
  function automatic logic is_busy(input nmr_state_e s);
    return (s == ST_ARM) || (s == ST_EXCITE) || (s == ST_DEAD) ||
           (s == ST_ACQ) || (s == ST_RELAX);
  endfunction

endpackage

// File: rtl/nmr_dwell_cnt.sv
// rtl/nmr_dwell_cnt.sv - loadable dwell down-counter with zero clamp and last-cycle flag
module nmr_dwell_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;

  // Load on state entry (0 treated as 1), then count down and park at 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= ONE;
    end else if (load) begin
      cnt <= (load_val == '0) ? ONE : load_val;
    end else if (cnt != ONE) begin
      cnt <= cnt - ONE;
    end
  end

  // The cycle in which the count reads 1 is the final cycle of the dwell
  assign last = (cnt == ONE);

endmodule

// File: rtl/nmr_seq_ctrl.sv
// rtl/nmr_seq_ctrl.sv - NMR echo-train sequencer; NMR_SEQ_PHASE_CYCLE_EN enables 0/180 amplitude cycling
module nmr_seq_ctrl
  import nmr_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int AMP_W   = 16,
  parameter int FREQ_W  = 32,
  parameter int ECHO_W  = 8,
  parameter int REP_W   = 16,
  parameter int RST_CYC = RST_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              start,
  input  logic [AMP_W-1:0]  cfg_amp,
  input  logic [FREQ_W-1:0] cfg_freq,
  input  logic [CNT_W-1:0]  cfg_t_exc,
  input  logic [CNT_W-1:0]  cfg_t_dead,
  input  logic [CNT_W-1:0]  cfg_t_acq,
  input  logic [CNT_W-1:0]  cfg_t_rep,
  input  logic [ECHO_W-1:0] cfg_n_echo,
  input  logic [REP_W-1:0]  cfg_n_rep,
  output logic              en_gen,
  output logic              en_acq,
  output logic [AMP_W-1:0]  amp_o,
  output logic [FREQ_W-1:0] freq_o,
  output logic              rst_writer,
  output logic              rst_pck,
  output logic              rst_f,
  output logic              busy,
  output logic              done,
  output logic [31:0]       sts,
  output logic [6:0]        leds
);

  nmr_state_e        state;
  nmr_state_e        state_n;
  logic [ECHO_W-1:0] echo_idx;
  logic [ECHO_W-1:0] echo_n;
  logic [REP_W-1:0]  rep_idx;
  logic [REP_W-1:0]  rep_n;

  // Shadow copies of the configuration, captured only when a run starts
  logic [AMP_W-1:0]  sh_amp;
  logic [FREQ_W-1:0] sh_freq;
  logic [CNT_W-1:0]  sh_t_exc;
  logic [CNT_W-1:0]  sh_t_dead;
  logic [CNT_W-1:0]  sh_t_acq;
  logic [CNT_W-1:0]  sh_t_rep;
  logic [ECHO_W-1:0] sh_n_echo;
  logic [REP_W-1:0]  sh_n_rep;

  logic [ECHO_W-1:0] echo_last;
  logic [REP_W-1:0]  rep_last;
  logic              cfg_latch;
  logic              dw_load;
  logic [CNT_W-1:0]  dw_val;
  logic              dw_last;
  logic [AMP_W-1:0]  amp_src;
  logic [AMP_W-1:0]  amp_n;
  logic [31:0]       sts_n;

  // Last valid index; a count of zero behaves as a count of one
  assign echo_last = (sh_n_echo == '0) ? '0 : sh_n_echo - ECHO_W'(1);
  assign rep_last  = (sh_n_rep == '0) ? '0 : sh_n_rep - REP_W'(1);

  // Capture cfg on the edge that enters ARM from IDLE or DONE
  assign cfg_latch = (state_n == ST_ARM) && (state != ST_ARM);

  // Every state entry reloads the shared dwell counter
  assign dw_load = (state_n != state);

  // Next state and next echo/rep indices
  always_comb begin
    state_n = state;
    echo_n  = echo_idx;
    rep_n   = rep_idx;
    if (!enable) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state_n = ST_ARM;
        end
        ST_ARM: begin
          if (dw_last) begin
            state_n = ST_EXCITE;
            echo_n  = '0;
            rep_n   = '0;
          end
        end
        ST_EXCITE: begin
          if (dw_last) state_n = ST_DEAD;
        end
        ST_DEAD: begin
          if (dw_last) state_n = ST_ACQ;
        end
        ST_ACQ: begin
          if (dw_last) begin
            if (echo_idx < echo_last) begin
              echo_n  = echo_idx + ECHO_W'(1);
              state_n = ST_EXCITE;
            end else if (rep_idx < rep_last) begin
              state_n = ST_RELAX;
            end else begin
              state_n = ST_DONE;
            end
          end
        end
        ST_RELAX: begin
          if (dw_last) begin
            rep_n   = rep_idx + REP_W'(1);
            echo_n  = '0;
            state_n = ST_EXCITE;
          end
        end
        ST_DONE: begin
          if (start) state_n = ST_ARM;
        end
        default: state_n = ST_IDLE;
      endcase
    end
    if ((state_n == ST_IDLE) || (state_n == ST_ARM)) begin
      echo_n = '0;
      rep_n  = '0;
    end
  end

  // Dwell length for the state about to be entered
  always_comb begin
    dw_val = CNT_W'(RST_CYC);
    case (state_n)
      ST_EXCITE: dw_val = sh_t_exc;
      ST_DEAD:   dw_val = sh_t_dead;
      ST_ACQ:    dw_val = sh_t_acq;
      ST_RELAX:  dw_val = sh_t_rep;
      default:   dw_val = CNT_W'(RST_CYC);
    endcase
  end

  nmr_dwell_cnt #(
    .W (CNT_W)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (dw_load),
    .load_val (dw_val),
    .last     (dw_last)
  );

`ifdef NMR_SEQ_PHASE_CYCLE_EN
  // Two's-complement negation; the most negative code saturates to the largest positive one
  function automatic logic [AMP_W-1:0] neg_sat(input logic [AMP_W-1:0] a);
    logic [AMP_W-1:0] most_neg;
    most_neg = {1'b1, {(AMP_W-1){1'b0}}};
    if (a == most_neg) return ~most_neg;
    return '0 - a;
  endfunction
`endif

  // Amplitude for the next cycle, using freshly captured cfg on the latch edge
  always_comb begin
    amp_src = cfg_latch ? cfg_amp : sh_amp;
`ifdef NMR_SEQ_PHASE_CYCLE_EN
    amp_n = rep_n[0] ? neg_sat(amp_src) : amp_src;
`else
    amp_n = amp_src;
`endif
  end

  // Status word assembled from the next state and indices
  always_comb begin
    sts_n = '0;
    sts_n[STS_STATE_LSB +: STS_STATE_W] = state_n;
    sts_n[STS_ECHO_LSB +: STS_ECHO_W]   = STS_ECHO_W'(echo_n);
    sts_n[STS_REP_LSB +: STS_REP_W]     = STS_REP_W'(rep_n);
  end

  // State, indices, shadow cfg and all outputs register on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      echo_idx   <= '0;
      rep_idx    <= '0;
      sh_amp     <= '0;
      sh_freq    <= '0;
      sh_t_exc   <= '0;
      sh_t_dead  <= '0;
      sh_t_acq   <= '0;
      sh_t_rep   <= '0;
      sh_n_echo  <= '0;
      sh_n_rep   <= '0;
      en_gen     <= 1'b0;
      en_acq     <= 1'b0;
      amp_o      <= '0;
      freq_o     <= '0;
      rst_writer <= 1'b1;
      rst_pck    <= 1'b1;
      rst_f      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      sts        <= '0;
      leds       <= '0;
    end else begin
      state    <= state_n;
      echo_idx <= echo_n;
      rep_idx  <= rep_n;
      if (cfg_latch) begin
        sh_amp    <= cfg_amp;
        sh_freq   <= cfg_freq;
        sh_t_exc  <= cfg_t_exc;
        sh_t_dead <= cfg_t_dead;
        sh_t_acq  <= cfg_t_acq;
        sh_t_rep  <= cfg_t_rep;
        sh_n_echo <= cfg_n_echo;
        sh_n_rep  <= cfg_n_rep;
      end
      en_gen     <= (state_n == ST_EXCITE);
      en_acq     <= (state_n == ST_ACQ);
      amp_o      <= amp_n;
      freq_o     <= cfg_latch ? cfg_freq : sh_freq;
      rst_writer <= (state_n == ST_IDLE) || (state_n == ST_ARM);
      rst_pck    <= (state_n == ST_IDLE) || (state_n == ST_ARM);
      rst_f      <= (state_n == ST_IDLE) || (state_n == ST_ARM);
      busy       <= is_busy(state_n);
      done       <= (state_n == ST_DONE);
      sts        <= sts_n;
      leds       <= {state_n == ST_DONE, is_busy(state_n), state_n == ST_EXCITE,
                     state_n == ST_DEAD, state_n == ST_ACQ, state_n == ST_RELAX, enable};
    end
  end

endmodule

// File: tb/tb_nmr_seq_ctrl.sv
// tb/tb_nmr_seq_ctrl.sv - randomized self-checking bench for nmr_seq_ctrl against a cycle schedule model
module tb_nmr_seq_ctrl;

  localparam int RST_CYC = 4;
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_ARM   = 4'd1;
  localparam logic [3:0] S_EXC   = 4'd2;
  localparam logic [3:0] S_DEAD  = 4'd3;
  localparam logic [3:0] S_ACQ   = 4'd4;
  localparam logic [3:0] S_RELAX = 4'd5;
  localparam logic [3:0] S_DONE  = 4'd6;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        start;
  logic [15:0] cfg_amp;
  logic [31:0] cfg_freq;
  logic [31:0] cfg_t_exc;
  logic [31:0] cfg_t_dead;
  logic [31:0] cfg_t_acq;
  logic [31:0] cfg_t_rep;
  logic [7:0]  cfg_n_echo;
  logic [15:0] cfg_n_rep;
  logic        en_gen;
  logic        en_acq;
  logic [15:0] amp_o;
  logic [31:0] freq_o;
  logic        rst_writer;
  logic        rst_pck;
  logic        rst_f;
  logic        busy;
  logic        done;
  logic [31:0] sts;
  logic [6:0]  leds;

  always #5 clk = ~clk;

  nmr_seq_ctrl #(
    .RST_CYC (RST_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .start      (start),
    .cfg_amp    (cfg_amp),
    .cfg_freq   (cfg_freq),
    .cfg_t_exc  (cfg_t_exc),
    .cfg_t_dead (cfg_t_dead),
    .cfg_t_acq  (cfg_t_acq),
    .cfg_t_rep  (cfg_t_rep),
    .cfg_n_echo (cfg_n_echo),
    .cfg_n_rep  (cfg_n_rep),
    .en_gen     (en_gen),
    .en_acq     (en_acq),
    .amp_o      (amp_o),
    .freq_o     (freq_o),
    .rst_writer (rst_writer),
    .rst_pck    (rst_pck),
    .rst_f      (rst_f),
    .busy       (busy),
    .done       (done),
    .sts        (sts),
    .leds       (leds)
  );

  typedef struct {
    int          t_exc;
    int          t_dead;
    int          t_acq;
    int          t_rep;
    int          n_echo;
    int          n_rep;
    logic [15:0] amp;
    logic [31:0] freq;
  } cfg_t;

  typedef struct {
    logic [3:0] st;
    int         echo;
    int         rep;
  } step_t;

  step_t       tl[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] cur_amp  = 16'h0;
  logic [31:0] cur_freq = 32'h0;

  function automatic cfg_t mk_cfg(input int te, input int td, input int ta, input int tr,
                                  input int ne, input int nr, input logic [15:0] a,
                                  input logic [31:0] f);
    cfg_t c;
    c.t_exc = te; c.t_dead = td; c.t_acq = ta; c.t_rep = tr;
    c.n_echo = ne; c.n_rep = nr; c.amp = a; c.freq = f;
    return c;
  endfunction

  function automatic int clamp1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic logic [15:0] exp_amp(input logic [15:0] a, input int rep);
    logic neg_en;
`ifdef NMR_SEQ_PHASE_CYCLE_EN
    neg_en = 1'b1;
`else
    neg_en = 1'b0;
`endif
    if (neg_en && (rep % 2 == 1)) begin
      if (a == 16'h8000) return 16'h7fff;
      return 16'h0000 - a;
    end
    return a;
  endfunction

  function automatic logic [127:0] exp_vec(input logic [3:0] st, input int echo, input int rep,
                                           input logic en);
    logic [31:0] s;
    logic [6:0]  l;
    logic        b;
    logic        d;
    logic        r;
    b = (st >= S_ARM) && (st <= S_RELAX);
    d = (st == S_DONE);
    r = (st == S_IDLE) || (st == S_ARM);
    s = {st, 4'b0, 8'(echo), 16'(rep)};
    l = {d, b, st == S_EXC, st == S_DEAD, st == S_ACQ, st == S_RELAX, en};
    return {34'b0, st == S_EXC, st == S_ACQ, r, r, r, b, d, l, s, exp_amp(cur_amp, rep), cur_freq};
  endfunction

  function automatic logic [127:0] obs_vec();
    return {34'b0, en_gen, en_acq, rst_writer, rst_pck, rst_f, busy, done, leds, sts, amp_o, freq_o};
  endfunction

  task automatic chk(input string tag, input logic [127:0] expv);
    logic [127:0] obs;
    obs = obs_vec();
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic scramble(input bit with_start);
    cfg_amp    = 16'($urandom);
    cfg_freq   = $urandom;
    cfg_t_exc  = $urandom_range(0, 40);
    cfg_t_dead = $urandom_range(0, 40);
    cfg_t_acq  = $urandom_range(0, 40);
    cfg_t_rep  = $urandom_range(0, 40);
    cfg_n_echo = 8'($urandom);
    cfg_n_rep  = 16'($urandom);
    start      = with_start ? 1'($urandom) : 1'b0;
  endtask

  task automatic push_n(input logic [3:0] st, input int d, input int e, input int r);
    step_t s;
    s.st = st; s.echo = e; s.rep = r;
    for (int k = 0; k < clamp1(d); k++) tl.push_back(s);
  endtask

  // Expected cycle-by-cycle schedule of one run, from ARM to the last busy cycle
  task automatic build(input cfg_t c);
    int ne;
    int nr;
    ne = clamp1(c.n_echo);
    nr = clamp1(c.n_rep);
    tl.delete();
    push_n(S_ARM, RST_CYC, 0, 0);
    for (int r = 0; r < nr; r++) begin
      for (int e = 0; e < ne; e++) begin
        push_n(S_EXC, c.t_exc, e, r);
        push_n(S_DEAD, c.t_dead, e, r);
        push_n(S_ACQ, c.t_acq, e, r);
      end
      if (r < nr - 1) push_n(S_RELAX, c.t_rep, ne - 1, r);
    end
  endtask

  task automatic run(input string tag, input cfg_t c, input int abort_at);
    int ne;
    int nr;
    ne = clamp1(c.n_echo);
    nr = clamp1(c.n_rep);
    @(negedge clk);
    cfg_amp    = c.amp;
    cfg_freq   = c.freq;
    cfg_t_exc  = 32'(c.t_exc);
    cfg_t_dead = 32'(c.t_dead);
    cfg_t_acq  = 32'(c.t_acq);
    cfg_t_rep  = 32'(c.t_rep);
    cfg_n_echo = 8'(c.n_echo);
    cfg_n_rep  = 16'(c.n_rep);
    start      = 1'b1;
    build(c);
    cur_amp  = c.amp;
    cur_freq = c.freq;
    @(negedge clk);
    for (int i = 0; i < tl.size(); i++) begin
      chk(tag, exp_vec(tl[i].st, tl[i].echo, tl[i].rep, 1'b1));
      if (i == abort_at) begin
        enable = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        chk({tag, "_abort"}, exp_vec(S_IDLE, 0, 0, 1'b0));
        enable = 1'b1;
        start  = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, exp_vec(S_IDLE, 0, 0, 1'b1));
        return;
      end
      scramble(1'b1);
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_done"}, exp_vec(S_DONE, ne - 1, nr - 1, 1'b1));
    @(negedge clk);
    chk({tag, "_done_hold"}, exp_vec(S_DONE, ne - 1, nr - 1, 1'b1));
  endtask

  initial begin
    cfg_t c;
    int   ab;
    rst    = 1'b1;
    enable = 1'b0;
    start  = 1'b0;
    scramble(1'b0);
    repeat (3) @(negedge clk);
    chk("reset", exp_vec(S_IDLE, 0, 0, 1'b0));

    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      scramble(1'b1);
      @(negedge clk);
      chk("idle_disabled", exp_vec(S_IDLE, 0, 0, 1'b0));
    end

    enable = 1'b1;
    start  = 1'b0;
    @(negedge clk);
    chk("idle_enabled", exp_vec(S_IDLE, 0, 0, 1'b1));

    c = mk_cfg(12, 3, 12, $urandom_range(0, 9), 1, 1, 16'($urandom), $urandom);
    run("single", c, -1);

    enable = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    chk("done_abort_wins", exp_vec(S_IDLE, 0, 0, 1'b0));
    enable = 1'b1;
    start  = 1'b0;
    @(negedge clk);
    chk("done_abort_idle", exp_vec(S_IDLE, 0, 0, 1'b1));

    c = mk_cfg($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6), 20, 3, 2,
               16'($urandom), $urandom);
    run("train", c, -1);

    c = mk_cfg(0, 0, 0, 0, 0, 0, 16'($urandom), $urandom);
    run("zero_clamp", c, -1);

    c = mk_cfg($urandom_range(2, 8), $urandom_range(2, 8), $urandom_range(2, 8),
               $urandom_range(2, 8), 2, 2, 16'($urandom), $urandom);
    ab = RST_CYC + c.t_exc + c.t_dead + c.t_acq / 2;
    run("abort_acq", c, ab);

    c = mk_cfg($urandom_range(1, 5), $urandom_range(0, 5), $urandom_range(1, 5),
               $urandom_range(0, 5), 2, 1, 16'($urandom), $urandom);
    run("restart", c, -1);

    c = mk_cfg(3, 2, 3, 4, 1, 2, 16'd1024, $urandom);
    run("phase_1024", c, -1);

    c = mk_cfg(3, 2, 3, 4, 2, 2, 16'h8000, $urandom);
    run("phase_min", c, -1);

    for (int k = 0; k < 6; k++) begin
      c = mk_cfg($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                 $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3),
                 16'($urandom), $urandom);
      run("random", c, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
